// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the hex display scanner.
// Holds the hex-to-segment table (active-low, bit order {g,f,e,d,c,b,a}),
// the all-dark segment pattern and the per-slot scan state encoding.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/hex2seg.sv
// hex2seg: combinational nibble to active-low 7-segment decoder.
module hex2seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/hex_display_scanner.sv
// hex_display_scanner: time-multiplexed driver for DIGITS hex digits on a
// common 7-segment bus. Every digit slot lasts PRESCALE cycles and opens with
// GUARD blanking cycles so the previous digit's segments never ghost onto the
// next anode. New values enter a one-deep pending buffer through a
// valid/ready handshake and are committed to the display register only on the
// last cycle of a frame, so a frame never shows a mix of old and new digits.
// Outputs are decoded from registered state plus the live mask only.
// Build option: define HEX_DISPLAY_LZ_BLANK_EN to blank leading-zero digits
// (digit 0 is always shown).
module hex_display_scanner
  import seg_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int PRESCALE = 100000,
  parameter int GUARD    = 1000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  input  logic [DIGITS-1:0]     mask_i,
  output logic [DIGITS-1:0]     an_o,
  output logic [6:0]            seg_o,
  output logic                  frame_o
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(DIGITS);

  localparam logic [CW-1:0] CNT_LAST       = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_GUARD_LAST = CW'(GUARD - 1);
  localparam logic [IW-1:0] IDX_LAST       = IW'(DIGITS - 1);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  scan_state_e         state_q, state_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [4*DIGITS-1:0] pend_q, pend_d;
  logic                pend_full_q, pend_full_d;

  logic                slot_end;
  logic                frame_end;
  logic                accept;
  logic [3:0]          nibs [DIGITS];
  logic [3:0]          sel_nib;
  logic [6:0]          sel_seg;
  logic                lz_blank;
  logic                show_lit;

  // Slot timing: counter, digit index and blank/show phase for the next cycle.
  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);

    cnt_d = slot_end ? '0 : cnt_q + CW'(1);

    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    state_d = state_q;
    case (state_q)
      BLANK:   if (cnt_q == CNT_GUARD_LAST) state_d = SHOW;
      SHOW:    if (slot_end)                state_d = BLANK;
      default:                              state_d = BLANK;
    endcase
  end

  // Input handshake and frame-boundary commit of the pending value.
  always_comb begin
    accept      = data_valid_i && !pend_full_q;
    pend_d      = accept ? data_i : pend_q;
    pend_full_d = pend_full_q;
    disp_d      = disp_q;
    // Commit and accept are mutually exclusive: accept needs an empty buffer,
    // commit needs a full one. A value taken on the frame_o cycle therefore
    // waits for the following frame boundary.
    if (frame_end && pend_full_q) begin
      disp_d      = pend_q;
      pend_full_d = 1'b0;
    end else if (accept) begin
      pend_full_d = 1'b1;
    end
  end

  // All scan and buffer state; reset discards any pending value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      state_q     <= BLANK;
      disp_q      <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      state_q     <= state_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_nib
    assign nibs[k] = disp_q[4*k +: 4];
  end

  assign sel_nib = nibs[idx_q];

  hex2seg u_hex2seg (
    .nibble_i (sel_nib),
    .seg_o    (sel_seg)
  );

`ifdef HEX_DISPLAY_LZ_BLANK_EN
  // Leading-zero detect: the current digit is dark when it and every digit
  // above it hold zero; digit 0 is never suppressed.
  always_comb begin
    logic upper_zero;
    lz_blank   = 1'b0;
    upper_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero && (nibs[k] == 4'h0);
      if ((IW'(k) == idx_q) && upper_zero) begin
        lz_blank = 1'b1;
      end
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  // Output decode from registered state and the live mask.
  always_comb begin
    show_lit = (state_q == SHOW) && mask_i[idx_q] && !lz_blank;
    an_o     = show_lit ? ~(DIGITS'(1) << idx_q) : '1;
    seg_o    = show_lit ? sel_seg : SEG_BLANK;
  end

  assign frame_o      = frame_end;
  assign data_ready_o = !pend_full_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// tb_hex_display_scanner: self-checking bench for hex_display_scanner with
// DIGITS=8, PRESCALE=8, GUARD=2. Accepted values are pushed to a scoreboard
// tagged with the frame in which they must become visible; the per-cycle
// model pops them at that frame and predicts an_o/seg_o/frame_o/data_ready_o.
module tb_hex_display_scanner;

  localparam int DIGITS   = 8;
  localparam int PRESCALE = 8;
  localparam int GUARD    = 2;
  localparam int FRAME    = DIGITS * PRESCALE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = '0;
  logic        valid = 1'b0;
  logic        ready;
  logic [7:0]  mask = 8'hFF;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        frame;

  always #5 clk = ~clk;

  hex_display_scanner #(
    .DIGITS   (DIGITS),
    .PRESCALE (PRESCALE),
    .GUARD    (GUARD)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_i       (data),
    .data_valid_i (valid),
    .data_ready_o (ready),
    .mask_i       (mask),
    .an_o         (an),
    .seg_o        (seg),
    .frame_o      (frame)
  );

  logic [6:0] tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    logic [31:0] val;
    int          frm;
  } sb_t;

  sb_t         sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc;
  logic [31:0] cur_disp;
  logic        pend_m;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_frame;
  logic        exp_ready;

  task automatic model_expect();
    int       idx;
    int       pos;
    logic [3:0] nib;
    logic     lit;
    sb_t      e;
    idx = (cyc / PRESCALE) % DIGITS;
    pos = cyc % PRESCALE;
    while (sb_q.size() > 0 && sb_q[0].frm <= cyc / FRAME) begin
      e = sb_q.pop_front();
      cur_disp = e.val;
    end
    nib = cur_disp[idx*4 +: 4];
    lit = (pos >= GUARD) && mask[idx];
`ifdef HEX_DISPLAY_LZ_BLANK_EN
    if (idx != 0 && (cur_disp >> (4*idx)) == 32'h0) lit = 1'b0;
`endif
    exp_an    = lit ? ~(8'h01 << idx) : 8'hFF;
    exp_seg   = lit ? tab[nib] : 7'h7F;
    exp_frame = (cyc % FRAME) == FRAME - 1;
    exp_ready = !pend_m;
  endtask

  task automatic tick(input logic v, input logic [31:0] d);
    sb_t e;
    valid = v;
    data  = d;
    if ((cyc % FRAME) == FRAME - 1 && pend_m) begin
      pend_m = 1'b0;
    end else if (v && !pend_m) begin
      e.val = d;
      e.frm = (cyc + 1) / FRAME + 1;
      sb_q.push_back(e);
      pend_m = 1'b1;
    end
    @(negedge clk);
    cyc++;
    model_expect();
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    valid = 1'b0;
    data  = '0;
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b0;
    cyc      = 0;
    sb_q.delete();
    cur_disp = '0;
    pend_m   = 1'b0;
    model_expect();
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    valid = 1'b1;
    data  = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if ({an, seg, frame, ready} !== {8'hFF, 7'h7F, 1'b0, 1'b1})
        $display("FAIL reset_hold i=%0d {an,seg,frame,ready} got=%h exp=%h", i,
                 {an, seg, frame, ready}, {8'hFF, 7'h7F, 1'b0, 1'b1});
      else n_pass++;
      n_checks++;
    end
    do_reset();
    if ({an, seg, frame, ready} !== {8'hFF, 7'h7F, 1'b0, 1'b1})
      $display("FAIL reset_release {an,seg,frame,ready} got=%h exp=%h",
               {an, seg, frame, ready}, {8'hFF, 7'h7F, 1'b0, 1'b1});
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_scan_idle();
    int frames_seen = 0;
    do_reset();
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      if ({an, seg, frame, ready} !== {exp_an, exp_seg, exp_frame, exp_ready})
        $display("FAIL scan_idle cyc=%0d {an,seg,frame,ready} got=%h exp=%h", cyc,
                 {an, seg, frame, ready}, {exp_an, exp_seg, exp_frame, exp_ready});
      else n_pass++;
      n_checks++;
      if (frame === 1'b1) frames_seen++;
      tick(1'b0, '0);
    end
    if (frames_seen != 2)
      $display("FAIL scan_idle_frames got=%0d exp=2", frames_seen);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_load();
    do_reset();
    for (int i = 0; i < 3 * FRAME; i++) begin
      if ({an, seg, frame, ready} !== {exp_an, exp_seg, exp_frame, exp_ready})
        $display("FAIL load cyc=%0d {an,seg,frame,ready} got=%h exp=%h", cyc,
                 {an, seg, frame, ready}, {exp_an, exp_seg, exp_frame, exp_ready});
      else n_pass++;
      n_checks++;
      if (cyc == 11 || cyc == 64) begin
        if (ready !== (cyc == 64))
          $display("FAIL load_ready cyc=%0d got=%b exp=%b", cyc, ready, cyc == 64);
        else n_pass++;
        n_checks++;
      end
      if (cyc == 58 || cyc == 66 || cyc == 122) begin
        if (seg !== ((cyc == 58) ? 7'h40 : (cyc == 66) ? 7'h0E : 7'h00))
          $display("FAIL load_digit cyc=%0d seg got=%h exp=%h", cyc, seg,
                   (cyc == 58) ? 7'h40 : (cyc == 66) ? 7'h0E : 7'h00);
        else n_pass++;
        n_checks++;
      end
      tick(cyc == 10, (cyc == 10) ? 32'h89AB_CDEF : 32'h0);
    end
  endtask

  task automatic test_back_to_back();
    logic        v;
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 4 * FRAME; i++) begin
      if ({an, seg, frame, ready} !== {exp_an, exp_seg, exp_frame, exp_ready})
        $display("FAIL back_to_back cyc=%0d {an,seg,frame,ready} got=%h exp=%h", cyc,
                 {an, seg, frame, ready}, {exp_an, exp_seg, exp_frame, exp_ready});
      else n_pass++;
      n_checks++;
      if (cyc == 66 || cyc == 130 || cyc == 138) begin
        if (seg !== ((cyc == 66) ? 7'h0E : (cyc == 130) ? 7'h40 : 7'h06))
          $display("FAIL back_to_back_digit cyc=%0d seg got=%h exp=%h", cyc, seg,
                   (cyc == 66) ? 7'h0E : (cyc == 130) ? 7'h40 : 7'h06);
        else n_pass++;
        n_checks++;
      end
      v = (cyc == 5) || (cyc == 20) || (cyc == 70);
      d = (cyc == 5) ? 32'h1357_9BDF : 32'h2468_ACE0;
      tick(v, d);
    end
  endtask

  task automatic test_frame_accept();
    do_reset();
    for (int i = 0; i < 3 * FRAME; i++) begin
      if ({an, seg, frame, ready} !== {exp_an, exp_seg, exp_frame, exp_ready})
        $display("FAIL frame_accept cyc=%0d {an,seg,frame,ready} got=%h exp=%h", cyc,
                 {an, seg, frame, ready}, {exp_an, exp_seg, exp_frame, exp_ready});
      else n_pass++;
      n_checks++;
      if (cyc == 66 || cyc == 130) begin
        if (seg !== ((cyc == 66) ? 7'h40 : 7'h78))
          $display("FAIL frame_accept_digit cyc=%0d seg got=%h exp=%h", cyc, seg,
                   (cyc == 66) ? 7'h40 : 7'h78);
        else n_pass++;
        n_checks++;
      end
      tick(cyc == 63, 32'h7777_7777);
    end
  endtask

  task automatic test_mask();
    mask = 8'b1111_0000;
    do_reset();
    for (int i = 0; i < 3 * FRAME; i++) begin
      if ({an, seg, frame, ready} !== {exp_an, exp_seg, exp_frame, exp_ready})
        $display("FAIL mask cyc=%0d {an,seg,frame,ready} got=%h exp=%h", cyc,
                 {an, seg, frame, ready}, {exp_an, exp_seg, exp_frame, exp_ready});
      else n_pass++;
      n_checks++;
      tick(cyc == 0, 32'h8888_8888);
    end
    mask = 8'hFF;
  endtask

  task automatic test_reset_mid();
    do_reset();
    while (cyc < 44) begin
      if ({an, seg, frame, ready} !== {exp_an, exp_seg, exp_frame, exp_ready})
        $display("FAIL reset_mid_pre cyc=%0d {an,seg,frame,ready} got=%h exp=%h", cyc,
                 {an, seg, frame, ready}, {exp_an, exp_seg, exp_frame, exp_ready});
      else n_pass++;
      n_checks++;
      tick(cyc == 3, 32'h5555_5555);
    end
    if ({an, ready} !== {8'hDF, 1'b0})
      $display("FAIL reset_mid_show {an,ready} got=%h exp=%h", {an, ready}, {8'hDF, 1'b0});
    else n_pass++;
    n_checks++;
    valid = 1'b0;
    rst   = 1'b1;
    #1;
    if ({an, seg, frame, ready} !== {8'hFF, 7'h7F, 1'b0, 1'b1})
      $display("FAIL reset_mid_async {an,seg,frame,ready} got=%h exp=%h",
               {an, seg, frame, ready}, {8'hFF, 7'h7F, 1'b0, 1'b1});
    else n_pass++;
    n_checks++;
    do_reset();
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      if ({an, seg, frame, ready} !== {exp_an, exp_seg, exp_frame, exp_ready})
        $display("FAIL reset_mid_post cyc=%0d {an,seg,frame,ready} got=%h exp=%h", cyc,
                 {an, seg, frame, ready}, {exp_an, exp_seg, exp_frame, exp_ready});
      else n_pass++;
      n_checks++;
      tick(1'b0, '0);
    end
  endtask

  task automatic test_lz();
    do_reset();
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      if ({an, seg, frame, ready} !== {exp_an, exp_seg, exp_frame, exp_ready})
        $display("FAIL lz cyc=%0d {an,seg,frame,ready} got=%h exp=%h", cyc,
                 {an, seg, frame, ready}, {exp_an, exp_seg, exp_frame, exp_ready});
      else n_pass++;
      n_checks++;
      if (cyc == 82) begin
        if ({an, seg} !== {8'hFB, 7'h30})
          $display("FAIL lz_digit2 {an,seg} got=%h exp=%h", {an, seg}, {8'hFB, 7'h30});
        else n_pass++;
        n_checks++;
      end
      tick(cyc == 0, 32'h0000_0300);
    end
  endtask

  initial begin
    test_reset();
    test_scan_idle();
    test_load();
    test_back_to_back();
    test_frame_accept();
    test_mask();
    test_reset_mid();
    test_lz();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
